// File: rtl/mips_pipe_pkg.sv
// Shared MIPS pipeline definitions: control-field bit positions, widths and
// the memory-stage FSM state type.
package mips_pipe_pkg;
  localparam int WB_REGWRITE = 1;
  localparam int WB_MEMTOREG = 0;
  localparam int M_BRANCH    = 2;
  localparam int M_MEMREAD   = 1;
  localparam int M_MEMWRITE  = 0;

  localparam int WB_W        = 2;
  localparam int M_W         = 3;
  localparam int REG_ADDR_W  = 5;
  localparam int XLEN        = 32;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } mem_state_t;
endpackage

// File: rtl/data_mem.sv
// Word-addressed data memory: synchronous write, asynchronous read, so the
// MEM/WB register can capture the old word on the same edge as a write.
module data_mem
  import mips_pipe_pkg::*;
#(
  parameter int MEM_WORDS = 256
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(MEM_WORDS)-1:0] idx,
  input  logic [XLEN-1:0]              wdata,
  output logic [XLEN-1:0]              rdata
);
  logic [XLEN-1:0] mem [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  assign rdata = mem[idx];
endmodule

// File: rtl/mem_stage.sv
// MIPS memory stage: branch resolution, fixed-latency data-memory access with
// upstream stall, and the MEM/WB pipeline register.
module mem_stage
  import mips_pipe_pkg::*;
#(
  parameter int MEM_WORDS   = 256,
  parameter int MEM_LATENCY = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [WB_W-1:0]       wb_in,
  input  logic [M_W-1:0]        m_in,
  input  logic [XLEN-1:0]       add2_in,
  input  logic [XLEN-1:0]       alu_in,
  input  logic [XLEN-1:0]       rd2_in,
  input  logic [REG_ADDR_W-1:0] dest_in,
  input  logic                  zero_in,
  output logic                  pcsrc,
  output logic [XLEN-1:0]       branch_target,
  output logic                  stall,
  output logic [WB_W-1:0]       wb_out,
  output logic [XLEN-1:0]       read_data_out,
  output logic [XLEN-1:0]       alu_out,
  output logic [REG_ADDR_W-1:0] dest_out
);
  localparam int IDX_W = $clog2(MEM_WORDS);
  localparam int CNT_W = $clog2(MEM_LATENCY) + 1;
  localparam logic [CNT_W-1:0] CNT_START = CNT_W'(MEM_LATENCY - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  mem_state_t       state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             memop, complete, mem_we;
  logic [IDX_W-1:0] word_idx;
  logic [XLEN-1:0]  mem_rdata;
  logic             unused_addr_bits;

  assign pcsrc         = m_in[M_BRANCH] & zero_in;
  assign branch_target = add2_in;

  // Byte offset and bits above the array size are dropped, so addresses wrap.
  assign word_idx         = alu_in[IDX_W+1:2];
  assign unused_addr_bits = ^{alu_in[XLEN-1:IDX_W+2], alu_in[1:0]};

  assign memop    = m_in[M_MEMREAD] | m_in[M_MEMWRITE];
  assign complete = memop & ((MEM_LATENCY == 1) | ((state_reg == WAIT) & (cnt_reg == CNT_ONE)));
  assign stall    = memop & ~complete & ~rst;
  assign mem_we   = complete & m_in[M_MEMWRITE] & ~rst;

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    case (state_reg)
      IDLE: begin
        if (memop && (MEM_LATENCY > 1)) begin
          state_next = WAIT;
          cnt_next   = CNT_START;
        end
      end
      WAIT: begin
        // A dropped memop mid-access abandons it without writing.
        if (!memop || complete) begin
          state_next = IDLE;
          cnt_next   = '0;
        end else if (cnt_reg > CNT_ONE) begin
          cnt_next = cnt_reg - CNT_ONE;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
    end
  end

  data_mem #(
    .MEM_WORDS(MEM_WORDS)
  ) u_data_mem (
    .clk   (clk),
    .we    (mem_we),
    .idx   (word_idx),
    .wdata (rd2_in),
    .rdata (mem_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      wb_out        <= '0;
      read_data_out <= '0;
      alu_out       <= '0;
      dest_out      <= '0;
    end else if (stall) begin
      wb_out <= '0;
    end else begin
      wb_out   <= wb_in;
      alu_out  <= alu_in;
      dest_out <= dest_in;
      if (m_in[M_MEMREAD]) read_data_out <= mem_rdata;
    end
  end
endmodule

// File: tb/tb_mem_stage.sv
// Randomized scoreboard bench for mem_stage: the driver predicts MEM/WB
// results from a word-array memory model, a monitor checks them as they emerge.
module tb_mem_stage;
  localparam int LAT   = 3;
  localparam int WORDS = 256;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  wb_in;
  logic [2:0]  m_in;
  logic [31:0] add2_in, alu_in, rd2_in;
  logic [4:0]  dest_in;
  logic        zero_in;
  logic        pcsrc, stall;
  logic [31:0] branch_target, read_data_out, alu_out;
  logic [1:0]  wb_out;
  logic [4:0]  dest_out;

  mem_stage #(
    .MEM_WORDS(WORDS),
    .MEM_LATENCY(LAT)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .wb_in         (wb_in),
    .m_in          (m_in),
    .add2_in       (add2_in),
    .alu_in        (alu_in),
    .rd2_in        (rd2_in),
    .dest_in       (dest_in),
    .zero_in       (zero_in),
    .pcsrc         (pcsrc),
    .branch_target (branch_target),
    .stall         (stall),
    .wb_out        (wb_out),
    .read_data_out (read_data_out),
    .alu_out       (alu_out),
    .dest_out      (dest_out)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [1:0]  wb;
    logic [31:0] alu;
    logic [4:0]  dest;
    logic [31:0] rd;
  } exp_t;

  exp_t        sbq[$];
  int          checks = 0;
  int          errors = 0;
  logic [31:0] model_mem [WORDS];
  logic [31:0] model_rd;

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", name, got, exp);
    end
  endtask

  // Called shortly after a falling edge; returns just after the falling edge
  // that follows the transaction's completing rising edge.
  task automatic issue(input logic [1:0] wb, input logic [2:0] m, input logic [31:0] add2,
                       input logic [31:0] alu, input logic [31:0] rd2, input logic [4:0] dest,
                       input logic z);
    int   idx, n;
    exp_t e;
    wb_in = wb; m_in = m; add2_in = add2; alu_in = alu; rd2_in = rd2;
    dest_in = dest; zero_in = z;
    #1;
    chk("pcsrc", 64'(pcsrc), 64'(m[2] & z));
    chk("branch_target", 64'(branch_target), 64'(add2));
    idx = int'((alu >> 2) % WORDS);
    if (m[1]) model_rd = model_mem[idx];
    if (m[0]) model_mem[idx] = rd2;
    e.wb = wb; e.alu = alu; e.dest = dest; e.rd = model_rd;
    sbq.push_back(e);
    n = 0;
    while (stall === 1'b1 && n < 20) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("stall_cycles", 64'(n), (m[1] | m[0]) ? 64'(LAT - 1) : 64'd0);
    $display("TXN m=%b wb=%b alu=%08h rd2=%08h stall_cycles=%0d exp_rd=%08h",
             m, wb, alu, rd2, n, model_rd);
    @(negedge clk);
  endtask

  // Monitor: classify each rising edge by the pre-edge rst/stall, then check.
  initial begin
    logic ps, pr;
    exp_t e;
    forever begin
      @(negedge clk);
      #3;
      ps = stall;
      pr = rst;
      @(posedge clk);
      #1;
      if (pr) begin
        chk("rst_wb_out", 64'(wb_out), 64'd0);
        chk("rst_read_data", 64'(read_data_out), 64'd0);
        chk("rst_alu_out", 64'(alu_out), 64'd0);
        chk("rst_dest_out", 64'(dest_out), 64'd0);
      end else if (ps) begin
        chk("bubble_wb_out", 64'(wb_out), 64'd0);
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        chk("wb_out", 64'(wb_out), 64'(e.wb));
        chk("alu_out", 64'(alu_out), 64'(e.alu));
        chk("dest_out", 64'(dest_out), 64'(e.dest));
        chk("read_data_out", 64'(read_data_out), 64'(e.rd));
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog expired got timeout expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [2:0] rm;
    for (int i = 0; i < WORDS; i++) model_mem[i] = '0;
    model_rd = '0;
    rst = 1'b1; wb_in = '0; m_in = '0; add2_in = '0; alu_in = '0;
    rd2_in = '0; dest_in = '0; zero_in = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    #1;
    chk("stall_idle", 64'(stall), 64'd0);

    issue(2'b10, 3'b000, 32'h0, 32'h1234, 32'h0, 5'd7, 1'b0);

    // Known contents for the words random traffic will touch.
    for (int i = 0; i < 16; i++)
      issue(2'b00, 3'b001, 32'h0, 32'(i * 4), $urandom, 5'd0, 1'b0);

    issue(2'b00, 3'b001, 32'h0, 32'h10, 32'hDEADBEEF, 5'd0, 1'b0);
    issue(2'b11, 3'b010, 32'h0, 32'h10, 32'h0, 5'd9, 1'b0);
    issue(2'b00, 3'b100, 32'h40, 32'h0, 32'h0, 5'd0, 1'b1);
    issue(2'b00, 3'b100, 32'h40, 32'h0, 32'h0, 5'd0, 1'b0);
    issue(2'b00, 3'b001, 32'h0, 32'h403, 32'hA5A5A5A5, 5'd0, 1'b0);
    issue(2'b11, 3'b010, 32'h0, 32'h000, 32'h0, 5'd2, 1'b0);
    issue(2'b00, 3'b001, 32'h0, 32'h4, 32'h11, 5'd0, 1'b0);
    issue(2'b11, 3'b011, 32'h0, 32'h4, 32'h22, 5'd3, 1'b0);
    issue(2'b11, 3'b010, 32'h0, 32'h4, 32'h0, 5'd4, 1'b0);

    // Reset on the second stall cycle of a store: the store must be lost.
    wb_in = 2'b10; m_in = 3'b001; alu_in = 32'h20; rd2_in = 32'h55; dest_in = 5'd3;
    #1;
    chk("rstmid_stall1", 64'(stall), 64'd1);
    @(negedge clk);
    #1;
    chk("rstmid_stall2", 64'(stall), 64'd1);
    rst = 1'b1;
    #1;
    chk("rstmid_stall_in_rst", 64'(stall), 64'd0);
    @(negedge clk);
    rst = 1'b0; m_in = 3'b000;
    model_rd = '0;
    #1;
    chk("rstmid_stall_after", 64'(stall), 64'd0);
    issue(2'b11, 3'b010, 32'h0, 32'h20, 32'h0, 5'd5, 1'b0);

    for (int t = 0; t < 150; t++) begin
      case ($urandom_range(0, 4))
        0: rm = 3'b000;
        1: rm = 3'b100;
        2: rm = 3'b010;
        3: rm = 3'b001;
        default: rm = 3'b011;
      endcase
      issue(2'($urandom), rm, $urandom, $urandom & ~32'h3C0, $urandom,
            5'($urandom), 1'($urandom));
    end

    m_in = 3'b000;
    repeat (3) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
